// File: rtl/ip_operand_sequencer.sv
// Ping-pong operand buffer feeding accelerator_unit: collects whole samples from a
// valid/ready stream, then replays each one as a gap-free burst of numCycle beats.
module ip_operand_sequencer #(
  parameter int inputBitwidth = 16,
  parameter int size          = 10,
  parameter int numCycle      = 25,
  parameter int logNumCycle   = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [inputBitwidth*size-1:0]   s_x,
  input  logic [inputBitwidth*size-1:0]   s_w,
  input  logic [inputBitwidth-1:0]        s_bias,
  input  logic                            s_last,
  output logic [inputBitwidth*size-1:0]   data_out_x,
  output logic [inputBitwidth*size-1:0]   data_out_w,
  output logic [inputBitwidth-1:0]        bias_out,
  output logic                            sel,
  output logic                            comb_valid,
  output logic                            issue_valid,
  output logic                            frame_err
);

  localparam int DW = inputBitwidth*size;
  localparam logic [logNumCycle-1:0] LAST = logNumCycle'(numCycle-1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  logic [DW-1:0]            mem_x_q [2][numCycle];
  logic [DW-1:0]            mem_w_q [2][numCycle];
  logic [inputBitwidth-1:0] bias_mem_q [2];

  state_e                   state_q, state_d;
  logic [1:0]               full_q, full_d;
  logic                     wbank_q, wbank_d, rbank_q, rbank_d;
  logic [logNumCycle-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic                     ready_q, ready_d;
  logic                     ferr_q, ferr_d;
  logic [DW-1:0]            x_q, x_d, w_q, w_d;
  logic [inputBitwidth-1:0] bias_q, bias_d;
  logic                     sel_q, sel_d, comb_q, comb_d, iss_q, iss_d;

  logic                     wr_fire, rd_issue;
  logic [logNumCycle-1:0]   rd_idx;

  // Registered ready is masked by rst so nothing is accepted while resetting.
  assign s_ready     = ready_q & ~rst;
  assign wr_fire     = s_valid & s_ready;

  assign data_out_x  = x_q;
  assign data_out_w  = w_q;
  assign bias_out    = bias_q;
  assign sel         = sel_q;
  assign comb_valid  = comb_q;
  assign issue_valid = iss_q;
  assign frame_err   = ferr_q;

  always_comb begin
    state_d  = state_q;
    full_d   = full_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
    ferr_d   = ferr_q;
    rd_issue = 1'b0;
    rd_idx   = rcnt_q;

    if (wr_fire) begin
      if (wcnt_q == LAST) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        wcnt_d          = '0;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
      if ((wcnt_q == LAST) != s_last) ferr_d = 1'b1;
    end

    // IDLE issues beat 0 itself so a fresh sample reaches the outputs two cycles after its last beat.
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          rd_issue = 1'b1;
          rd_idx   = '0;
        end
      end
      BURST: rd_issue = 1'b1;
      default: ;
    endcase

    if (rd_issue) begin
      if (rd_idx == LAST) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
        rcnt_d          = '0;
        state_d         = full_q[~rbank_q] ? BURST : IDLE;
      end else begin
        rcnt_d  = rd_idx + 1'b1;
        state_d = BURST;
      end
    end

    ready_d = ~full_d[wbank_d];

    iss_d  = rd_issue;
    sel_d  = rd_issue && (rd_idx != '0);
    comb_d = rd_issue && (rd_idx == LAST);
    x_d    = rd_issue ? mem_x_q[rbank_q][rd_idx] : '0;
    w_d    = rd_issue ? mem_w_q[rbank_q][rd_idx] : '0;
    bias_d = (rd_issue && rd_idx == '0) ? bias_mem_q[rbank_q] : bias_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      ready_q <= 1'b1;
      ferr_q  <= 1'b0;
      x_q     <= '0;
      w_q     <= '0;
      bias_q  <= '0;
      sel_q   <= 1'b0;
      comb_q  <= 1'b0;
      iss_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      x_q     <= x_d;
      w_q     <= w_d;
      bias_q  <= bias_d;
      sel_q   <= sel_d;
      comb_q  <= comb_d;
      iss_q   <= iss_d;
    end
  end

  // Sample storage needs no reset; the full flags alone say what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_x_q[wbank_q][wcnt_q] <= s_x;
      mem_w_q[wbank_q][wcnt_q] <= s_w;
      if (wcnt_q == '0) bias_mem_q[wbank_q] <= s_bias;
    end
  end

endmodule

// File: tb/tb_ip_operand_sequencer.sv
// Randomized bench for ip_operand_sequencer: a sample/burst-schedule model predicts
// every output each cycle; a few literal checks pin the model's timing and data.
module tb_ip_operand_sequencer;
  localparam int W = 16, L = 10, N = 25, DW = W*L, MAXS = 32;

  logic          clk = 1'b0, rst = 1'b1;
  logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [DW-1:0] s_x = '0, s_w = '0, data_out_x, data_out_w;
  logic [W-1:0]  s_bias = '0, bias_out;
  logic          sel, comb_valid, issue_valid, frame_err;

  ip_operand_sequencer #(.inputBitwidth(W), .size(L), .numCycle(N), .logNumCycle(5)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_w(s_w),
    .s_bias(s_bias), .s_last(s_last), .data_out_x(data_out_x), .data_out_w(data_out_w),
    .bias_out(bias_out), .sel(sel), .comb_valid(comb_valid), .issue_valid(issue_valid),
    .frame_err(frame_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passes = 0;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Model: sample n completes at mt[n]; its burst is visible from
  // ms[n] = max(mt[n]+2, ms[n-1]+N). Bank of sample n frees for sample n+2 at ms[n]+N-1.
  logic [DW-1:0] mx [MAXS][N];
  logic [DW-1:0] mw [MAXS][N];
  logic [W-1:0]  mb [MAXS];
  int            mt [MAXS];
  int            ms [MAXS];
  int            nsamp = 0, wbeat = 0;
  bit            mferr = 1'b0;

  always @(negedge clk) begin : model
    logic [DW-1:0] ex, ew;
    logic [W-1:0]  eb;
    logic          ei, es, ec, er;
    int            k;
    if (cyc > 0) begin
      ex = '0; ew = '0; eb = '0; ei = 1'b0; es = 1'b0; ec = 1'b0;
      for (int n = 0; n < nsamp; n++) begin
        if (ms[n] <= cyc) begin
          eb = mb[n];
          if (cyc < ms[n] + N) begin
            k  = cyc - ms[n];
            ex = mx[n][k]; ew = mw[n][k];
            ei = 1'b1; es = (k != 0); ec = (k == N-1);
          end
        end
      end
      er = !rst && (nsamp < 2 || cyc >= ms[nsamp-2] + N - 1);
      chk("s_ready",     DW'(s_ready),     DW'(er));
      chk("issue_valid", DW'(issue_valid), DW'(ei));
      chk("sel",         DW'(sel),         DW'(es));
      chk("comb_valid",  DW'(comb_valid),  DW'(ec));
      chk("data_out_x",  data_out_x,       ex);
      chk("data_out_w",  data_out_w,       ew);
      chk("bias_out",    DW'(bias_out),    DW'(eb));
      chk("frame_err",   DW'(frame_err),   DW'(mferr));
      if (!rst && s_valid && er) begin
        if (nsamp < MAXS) begin
          mx[nsamp][wbeat] = s_x;
          mw[nsamp][wbeat] = s_w;
          if (wbeat == 0) mb[nsamp] = s_bias;
        end
        if ((wbeat == N-1) != s_last) mferr = 1'b1;
        if (wbeat == N-1) begin
          if (nsamp < MAXS) begin
            mt[nsamp] = cyc;
            ms[nsamp] = (nsamp == 0) ? cyc + 2 :
                        ((cyc + 2 > ms[nsamp-1] + N) ? cyc + 2 : ms[nsamp-1] + N);
            nsamp++;
          end
          wbeat = 0;
        end else begin
          wbeat++;
        end
      end
      if (rst) begin
        nsamp = 0; wbeat = 0; mferr = 1'b0;
      end
    end
  end

  // Burst run monitor: length and first cycle of each contiguous issue_valid run.
  int run_cur = 0, last_run = 0, runs_done = 0, run_start = 0, run_first = 0;
  always @(negedge clk) begin
    if (issue_valid === 1'b1) begin
      if (run_cur == 0) run_first = cyc;
      run_cur++;
    end else if (run_cur > 0) begin
      last_run  = run_cur;
      run_start = run_first;
      run_cur   = 0;
      runs_done++;
    end
  end

  // Drives one sample (or its first nb beats); mode 0: x=k, w=2k lanes, else random.
  task automatic send_sample(input int mode, input logic [W-1:0] b, input int gap,
                             input int lastpos, input int nb, input bit keep, output int tl);
    int t;
    tl = -1;
    for (int k = 0; k < nb; k++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      for (int l = 0; l < L; l++) begin
        s_x[l*W +: W] = (mode == 0) ? W'(k)   : W'($urandom);
        s_w[l*W +: W] = (mode == 0) ? W'(2*k) : W'($urandom);
      end
      s_bias  = (k == 0) ? b : W'($urandom);
      s_last  = (k == lastpos);
      s_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (s_ready !== 1'b1 && t <= 300) begin
        t++;
        @(negedge clk);
      end
      chk("ready_wait", DW'(t <= 300), DW'(1));
      @(posedge clk); #1;
      tl = cyc - 1;
    end
    if (!keep) s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_run();
    int prior, t;
    prior = runs_done; t = 0;
    while (runs_done == prior && t < 400) begin
      @(posedge clk); t++;
    end
    #1;
    chk("run_timeout", DW'(runs_done != prior), DW'(1));
  endtask

  initial begin
    int tl, tl0, c0, cnt;
    logic [DW-1:0] lx, lw;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_issue",  DW'(issue_valid), DW'(0));
    chk("rst_ready",  DW'(s_ready),     DW'(1));
    chk("rst_ferr",   DW'(frame_err),   DW'(0));
    chk("rst_bias",   DW'(bias_out),    DW'(0));
    @(posedge clk); #1;

    // 1: single counting sample, literal timing and data
    send_sample(0, 16'd7, 0, N-1, N, 1'b0, tl);
    @(negedge clk);
    chk("t1_pre_burst", DW'(issue_valid), DW'(0));
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      for (int l = 0; l < L; l++) begin
        lx[l*W +: W] = W'(k);
        lw[l*W +: W] = W'(2*k);
      end
      chk("t1_issue", DW'(issue_valid), DW'(1));
      chk("t1_sel",   DW'(sel),         DW'(k != 0));
      chk("t1_comb",  DW'(comb_valid),  DW'(k == N-1));
      chk("t1_x",     data_out_x,       lx);
      chk("t1_w",     data_out_w,       lw);
      chk("t1_bias",  DW'(bias_out),    DW'(7));
    end
    @(negedge clk);
    chk("t1_post_burst", DW'(issue_valid), DW'(0));
    @(posedge clk); #1;

    // 2 (+6): three samples streamed; bank freed exactly as the writer reaches it
    c0 = cyc;
    send_sample(1, 16'h0101, 0, N-1, N, 1'b1, tl);
    send_sample(1, 16'h0202, 0, N-1, N, 1'b1, tl);
    send_sample(1, 16'h0303, 0, N-1, N, 1'b0, tl);
    chk("t2_no_stall", DW'(cyc - c0), DW'(3*N));
    wait_run();
    chk("t2_run_len", DW'(last_run), DW'(3*N));

    // 3: random gaps inside a sample
    send_sample(1, 16'h1234, 50, N-1, N, 1'b0, tl);
    wait_run();
    chk("t3_run_len", DW'(last_run),  DW'(N));
    chk("t3_start",   DW'(run_start), DW'(tl + 2));

    // random phase
    for (int s = 0; s < 6; s++)
      send_sample(1, W'($urandom), $urandom_range(0, 70), N-1, N, bit'($urandom_range(0, 1)), tl);
    s_valid = 1'b0;
    repeat (80) @(posedge clk);
    #1;

    // 4: misplaced s_last
    send_sample(1, 16'h00aa, 20, 10, N, 1'b0, tl);
    chk("t4_ferr", DW'(frame_err), DW'(1));
    wait_run();
    chk("t4_run_len",    DW'(last_run),  DW'(N));
    chk("t4_ferr_stick", DW'(frame_err), DW'(1));

    // 5: reset at burst beat 12 while the other bank is partly written
    send_sample(0, 16'd9, 0, N-1, N, 1'b1, tl0);
    send_sample(1, 16'd5, 0, N-1, 12, 1'b0, tl);
    while (cyc < tl0 + 14) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    for (int l = 0; l < L; l++) lx[l*W +: W] = W'(12);
    chk("t5_ready_in_rst", DW'(s_ready),     DW'(0));
    chk("t5_beat12",       DW'(issue_valid), DW'(1));
    chk("t5_beat12_x",     data_out_x,       lx);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_issue0", DW'(issue_valid), DW'(0));
    chk("t5_x0",     data_out_x,       DW'(0));
    chk("t5_bias0",  DW'(bias_out),    DW'(0));
    chk("t5_ready1", DW'(s_ready),     DW'(1));
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (issue_valid) cnt++;
    end
    chk("t5_quiet", DW'(cnt), DW'(0));
    @(posedge clk); #1;
    send_sample(1, 16'h4321, 30, N-1, N, 1'b0, tl);
    wait_run();
    chk("t5_recover_len", DW'(last_run),  DW'(N));
    chk("t5_recover_st",  DW'(run_start), DW'(tl + 2));
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
